nn_exec_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the NN processor core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the two-stage ALU (ALU1 then ALU2), register-file write enable and data-memory handshake.
- Handles MAC as a two-pass operation, stops on HALT, and flags illegal opcodes and memory timeouts.

---
 rtl/nn_isa_pkg.sv | 39 +++
 rtl/nn_seq_decode.sv | 48 ++++
 rtl/nn_exec_sequencer.sv | 139 +++++++++++++
 tb/tb_nn_exec_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_isa_pkg.sv
// Opcode, ALU-op and sequencer state encodings shared by the NN execution sequencer.
package nn_isa_pkg;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_MUL  = 4'h2;
    localparam logic [3:0] OPC_SLT  = 4'h3;
    localparam logic [3:0] OPC_MAC  = 4'h4;
    localparam logic [3:0] OPC_HALT = 4'hB;
    localparam logic [3:0] OPC_LD   = 4'hE;
    localparam logic [3:0] OPC_ST   = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b111;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_EXEC2  = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    typedef struct packed {
        logic       is_arith;
        logic       is_mac;
        logic       is_mem;
        logic       is_store;
        logic       is_nop;
        logic       is_halt;
        logic       illegal;
        logic [2:0] alu1Code;
    } decode_t;

endpackage

// File: rtl/nn_seq_decode.sv
// Opcode classifier for the execution sequencer.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode input.
module nn_seq_decode
    import nn_isa_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output decode_t          dec
);

    always_comb begin
        dec          = '0;
        dec.alu1Code = ALU_NONE;
        case (opcode)
            OPC_W'(OPC_NOP):  dec.is_nop = 1'b1;
            OPC_W'(OPC_HALT): dec.is_halt = 1'b1;
            OPC_W'(OPC_ADD): begin
                dec.is_arith = 1'b1;
                dec.alu1Code = ALU_ADD;
            end
            OPC_W'(OPC_MUL): begin
                dec.is_arith = 1'b1;
                dec.alu1Code = ALU_MUL;
            end
            OPC_W'(OPC_SLT): begin
                dec.is_arith = 1'b1;
                dec.alu1Code = ALU_SLT;
            end
            OPC_W'(OPC_MAC): begin
                dec.is_mac   = 1'b1;
                dec.alu1Code = ALU_MUL;
            end
            OPC_W'(OPC_LD): begin
                dec.is_mem   = 1'b1;
                dec.alu1Code = ALU_ADD;
            end
            OPC_W'(OPC_ST): begin
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
                dec.alu1Code = ALU_ADD;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/nn_exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer driving ALU, regfile and data memory.
// Latency: fetch_req to retire is 2 (NOP), 4 (ALU, ST), 5 (MAC, LD) cycles with immediate handshakes.
// Backpressure: stalls in FETCH until instr_valid and in MEM until mem_ack (bounded by MEM_WAIT_MAX).
module nn_exec_sequencer
    import nn_isa_pkg::*;
#(
    parameter int OPC_W        = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             instr_valid,
    input  logic [OPC_W-1:0] opcode,
    output logic             fetch_req,
    output logic             ir_load,
    output logic             pc_inc,
    output logic [2:0]       alu_ctl1,
    output logic [2:0]       alu_ctl2,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [3:0]        state;
    logic [3:0]        stateNxt;
    logic [OPC_W-1:0]  opcReg;
    logic [WAIT_W-1:0] waitCnt;
    logic [CNT_W-1:0]  retireCnt;
    logic              retire;
    logic              waitLimit;
    decode_t           dec;

    nn_seq_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode (opcReg),
        .dec    (dec)
    );

    assign waitLimit = (waitCnt == WAIT_W'(MEM_WAIT_MAX - 1));

    // HALT retires in DECODE without a PC advance; ST retires on the ack cycle itself.
    assign retire = ((state == S_DECODE) && (dec.is_nop || dec.is_halt))
                 || ((state == S_MEM) && mem_ack && dec.is_store)
                 || (state == S_WB);

    always_comb begin
        stateNxt = state;
        case (state)
            S_IDLE:   if (start) stateNxt = S_FETCH;
            S_FETCH:  if (instr_valid) stateNxt = S_DECODE;
            S_DECODE: begin
                if (dec.is_nop)       stateNxt = S_FETCH;
                else if (dec.is_halt) stateNxt = S_HALT;
                else if (dec.illegal) stateNxt = S_ERR;
                else                  stateNxt = S_EXEC;
            end
            S_EXEC: begin
                if (dec.is_mac)        stateNxt = S_EXEC2;
                else if (dec.is_mem)   stateNxt = S_MEM;
                else if (dec.is_arith) stateNxt = S_WB;
                else                   stateNxt = S_ERR;
            end
            S_EXEC2:  stateNxt = S_WB;
            S_MEM: begin
                if (mem_ack)        stateNxt = dec.is_store ? S_FETCH : S_WB;
                else if (waitLimit) stateNxt = S_ERR;
            end
            S_WB:     stateNxt = S_FETCH;
            S_HALT:   if (start) stateNxt = S_FETCH;
            S_ERR:    stateNxt = S_ERR;
            default:  stateNxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            opcReg    <= '0;
            waitCnt   <= '0;
            retireCnt <= '0;
        end else begin
            state <= stateNxt;
            if (ir_load) opcReg <= opcode;
            if ((state == S_MEM) && (stateNxt == S_MEM)) waitCnt <= waitCnt + 1'b1;
            else                                         waitCnt <= '0;
            if (retire) retireCnt <= retireCnt + 1'b1;
        end
    end

    always_comb begin
        fetch_req  = 1'b0;
        pc_inc     = 1'b0;
        alu_ctl1   = ALU_NONE;
        alu_ctl2   = ALU_NONE;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            S_FETCH:  fetch_req = 1'b1;
            S_DECODE: pc_inc = dec.is_nop;
            S_EXEC:   alu_ctl1 = dec.alu1Code;
            S_EXEC2: begin
                alu_ctl1 = ALU_MUL;
                alu_ctl2 = ALU_ADD;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = dec.is_store;
                alu_ctl1 = dec.alu1Code;
                pc_inc   = mem_ack && dec.is_store;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = dec.is_mem && !dec.is_store;
                pc_inc     = 1'b1;
                alu_ctl1   = dec.alu1Code;
                alu_ctl2   = dec.is_mac ? ALU_ADD : ALU_NONE;
            end
            default: ;
        endcase
    end

    assign ir_load     = fetch_req && instr_valid;
    assign busy        = (state != S_IDLE) && (state != S_HALT) && (state != S_ERR);
    assign halted      = (state == S_HALT);
    assign err         = (state == S_ERR);
    assign instr_count = retireCnt;

endmodule

// File: tb/tb_nn_exec_sequencer.sv
// Randomized scoreboard bench: per-instruction expected output traces against the sequencer.
module tb_nn_exec_sequencer;
    import nn_isa_pkg::*;

    localparam int WMAX   = 15;
    localparam int O_NEXT = 0;
    localparam int O_HALT = 1;
    localparam int O_ERR  = 2;
    localparam int O_RST  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, instr_valid, mem_ack;
    logic [3:0]  opcode;
    logic        fetch_req, ir_load, pc_inc, mem_req, mem_we, reg_write, mem_to_reg, busy, halted, err;
    logic [2:0]  alu_ctl1, alu_ctl2;
    logic [15:0] instr_count;
    logic        w_fetch_req, w_ir_load, w_pc_inc, w_mem_req, w_mem_we, w_reg_write, w_mem_to_reg;
    logic        w_busy, w_halted, w_err;
    logic [2:0]  w_alu_ctl1, w_alu_ctl2, w_instr_count;

    nn_exec_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid), .opcode(opcode),
        .fetch_req(fetch_req), .ir_load(ir_load), .pc_inc(pc_inc), .alu_ctl1(alu_ctl1),
        .alu_ctl2(alu_ctl2), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted),
        .err(err), .instr_count(instr_count)
    );

    // Narrow-counter twin sharing all stimulus: exercises counter wrap within a short run.
    nn_exec_sequencer #(.CNT_W(3)) dutWrap (
        .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid), .opcode(opcode),
        .fetch_req(w_fetch_req), .ir_load(w_ir_load), .pc_inc(w_pc_inc), .alu_ctl1(w_alu_ctl1),
        .alu_ctl2(w_alu_ctl2), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_ack(mem_ack),
        .reg_write(w_reg_write), .mem_to_reg(w_mem_to_reg), .busy(w_busy), .halted(w_halted),
        .err(w_err), .instr_count(w_instr_count)
    );

    typedef struct packed {
        logic        fetchReq;
        logic        irLoad;
        logic        pcInc;
        logic [2:0]  alu1;
        logic [2:0]  alu2;
        logic        memReq;
        logic        memWe;
        logic        regWrite;
        logic        memToReg;
        logic        busy;
        logic        halted;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    obs_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   mcnt    = 0;
    bit   monOn   = 1'b0;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return op inside {OPC_NOP, OPC_ADD, OPC_MUL, OPC_SLT, OPC_MAC, OPC_HALT, OPC_LD, OPC_ST};
    endfunction

    function automatic logic [2:0] aluOf(input logic [3:0] op);
        if (op == OPC_MUL || op == OPC_MAC) return ALU_MUL;
        if (op == OPC_SLT) return ALU_SLT;
        return ALU_ADD;
    endfunction

    function automatic obs_t base();
        obs_t e;
        e      = '0;
        e.alu1 = ALU_NONE;
        e.alu2 = ALU_NONE;
        e.cnt  = mcnt[15:0];
        return e;
    endfunction

    task automatic check(input bit ok, input string name, input obs_t got, input obs_t want);
        nChecks++;
        if (ok) nPass++;
        else $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
    endtask

    always @(negedge clk) begin : monitor
        obs_t got, gotW, want, wantW;
        if (monOn) begin
            got  = {fetch_req, ir_load, pc_inc, alu_ctl1, alu_ctl2, mem_req, mem_we, reg_write,
                    mem_to_reg, busy, halted, err, instr_count};
            gotW = {w_fetch_req, w_ir_load, w_pc_inc, w_alu_ctl1, w_alu_ctl2, w_mem_req, w_mem_we,
                    w_reg_write, w_mem_to_reg, w_busy, w_halted, w_err, 13'd0, w_instr_count};
            if (expQ.size() == 0) begin
                check(1'b0, "scoreboard_underflow", got, '0);
            end else begin
                want      = expQ.pop_front();
                wantW     = want;
                wantW.cnt = {13'd0, want.cnt[2:0]};
                check(got == want, "outputs", got, want);
                check(gotW == wantW, "outputs_cnt3", gotW, wantW);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic s, input logic iv, input logic [3:0] op,
                        input logic ack, input obs_t e);
        @(posedge clk);
        #1;
        reset       = r;
        start       = s;
        instr_valid = iv;
        opcode      = op;
        mem_ack     = ack;
        expQ.push_back(e);
        monOn = 1'b1;
    endtask

    task automatic runInstr(input logic [3:0] op, input int fw, input int ad, input int rstAt,
                            output int outc);
        obs_t e;
        bit   ack;
        outc = O_NEXT;
        for (int i = 0; i < fw; i++) begin
            e = base(); e.fetchReq = 1'b1; e.busy = 1'b1;
            step(1'b0, rb(), 1'b0, rop(), rb(), e);
        end
        e = base(); e.fetchReq = 1'b1; e.irLoad = 1'b1; e.busy = 1'b1;
        step(1'b0, rb(), 1'b1, op, rb(), e);
        e = base(); e.busy = 1'b1; e.pcInc = (op == OPC_NOP);
        step(1'b0, rb(), rb(), rop(), rb(), e);
        if (op == OPC_NOP) begin mcnt++; return; end
        if (op == OPC_HALT) begin mcnt++; outc = O_HALT; return; end
        if (!legal(op)) begin outc = O_ERR; return; end
        e = base(); e.busy = 1'b1; e.alu1 = aluOf(op);
        step(1'b0, rb(), rb(), rop(), rb(), e);
        if (op == OPC_MAC) begin
            e = base(); e.busy = 1'b1; e.alu1 = ALU_MUL; e.alu2 = ALU_ADD;
            step(1'b0, rb(), rb(), rop(), rb(), e);
            e.regWrite = 1'b1; e.pcInc = 1'b1;
            step(1'b0, rb(), rb(), rop(), rb(), e);
            mcnt++;
            return;
        end
        if (op == OPC_LD || op == OPC_ST) begin
            for (int k = 0; k < WMAX; k++) begin
                e = base(); e.busy = 1'b1; e.memReq = 1'b1; e.memWe = (op == OPC_ST); e.alu1 = ALU_ADD;
                if (k == rstAt) begin
                    step(1'b1, rb(), rb(), rop(), (op == OPC_LD) ? rb() : 1'b0, e);
                    mcnt = 0;
                    outc = O_RST;
                    return;
                end
                ack     = (k == ad);
                e.pcInc = ack && (op == OPC_ST);
                step(1'b0, rb(), rb(), rop(), ack, e);
                if (ack) break;
            end
            if (ad >= WMAX) begin outc = O_ERR; return; end
            if (op == OPC_ST) begin mcnt++; return; end
            e = base(); e.busy = 1'b1; e.regWrite = 1'b1; e.memToReg = 1'b1; e.pcInc = 1'b1;
            e.alu1 = ALU_ADD;
            step(1'b0, rb(), rb(), rop(), rb(), e);
            mcnt++;
            return;
        end
        e = base(); e.busy = 1'b1; e.regWrite = 1'b1; e.pcInc = 1'b1; e.alu1 = aluOf(op);
        step(1'b0, rb(), rb(), rop(), rb(), e);
        mcnt++;
    endtask

    task automatic idleStart();
        obs_t e;
        e = base();
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rb(), rop(), rb(), e);
        step(1'b0, 1'b1, rb(), rop(), rb(), e);
    endtask

    task automatic handle(input int outc);
        obs_t e;
        if (outc == O_HALT) begin
            e = base(); e.halted = 1'b1;
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, rb(), rop(), rb(), e);
            step(1'b0, 1'b1, rb(), rop(), rb(), e);
        end else if (outc == O_ERR) begin
            e = base(); e.err = 1'b1;
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b1, rb(), rop(), rb(), e);
            step(1'b1, rb(), rb(), rop(), rb(), e);
            mcnt = 0;
            idleStart();
        end else if (outc == O_RST) begin
            idleStart();
        end
    endtask

    task automatic run(input logic [3:0] op, input int fw, input int ad, input int rstAt);
        int outc;
        runInstr(op, fw, ad, rstAt, outc);
        handle(outc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legalOps[8];
        logic [3:0] badOps[8];
        logic [3:0] op;
        int         ad, rstAt, r;
        legalOps = '{OPC_NOP, OPC_ADD, OPC_MUL, OPC_SLT, OPC_MAC, OPC_HALT, OPC_LD, OPC_ST};
        badOps   = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD};
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0; opcode = 4'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        idleStart();

        run(OPC_ADD, 0, 0, -1);
        run(OPC_MAC, 1, 0, -1);
        run(OPC_LD, 0, 2, -1);
        run(OPC_ST, 0, 0, -1);
        run(OPC_ST, 0, WMAX - 1, -1);
        run(OPC_SLT, 2, 0, -1);
        run(OPC_MUL, 0, 0, -1);
        run(OPC_HALT, 0, 0, -1);
        repeat (9) run(OPC_NOP, 0, 0, -1);
        run(OPC_ST, 0, 99, -1);
        run(OPC_ADD, 0, 0, -1);
        run(4'h5, 0, 0, -1);
        run(OPC_NOP, 0, 0, -1);
        run(OPC_LD, 0, 5, 2);

        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 99);
            op = (r < 4) ? badOps[$urandom_range(0, 7)] : legalOps[$urandom_range(0, 7)];
            r  = $urandom_range(0, 99);
            ad = (r < 70) ? $urandom_range(0, 4) : (r < 93) ? $urandom_range(5, WMAX - 1) : WMAX;
            rstAt = -1;
            if (op == OPC_LD && ad > 0 && $urandom_range(0, 99) < 8) rstAt = $urandom_range(0, ad - 1);
            run(op, $urandom_range(0, 2), ad, rstAt);
        end

        @(negedge clk);
        #1;
        monOn = 1'b0;
        nChecks++;
        if (expQ.size() == 0) nPass++;
        else $display("FAIL scoreboard_leftover: got %0d entries want 0", expQ.size());
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
